// File: rtl/sargantana_icache_pkg.sv
// Shared types and geometry for the Sargantana instruction-cache controller.
// The optional performance counters are enabled with the ICACHE_PERF_CNT_EN macro.
package sargantana_icache_pkg;

  localparam int ICACHE_N_WAY     = 4;
  localparam int ICACHE_WAY_IDX_W = $clog2(ICACHE_N_WAY);
  localparam int ICACHE_N_SETS    = 16;
  localparam int ICACHE_IDX_WIDTH = $clog2(ICACHE_N_SETS);

  typedef logic [ICACHE_N_WAY-1:0]     way_vec_t;
  typedef logic [ICACHE_IDX_WIDTH-1:0] set_idx_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPARE   = 3'd1,
    MISS_REQ  = 3'd2,
    MISS_WAIT = 3'd3,
    REFILL    = 3'd4,
    FLUSH     = 3'd5,
    KILL_WAIT = 3'd6
  } icache_state_e;

  // 8-bit Fibonacci LFSR step, taps 8,6,5,4 (bits 7,5,4,3), shifting left.
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

endpackage

// File: rtl/sargantana_icache_ctrl_if.sv
// Fetch / tag-checker / memory / flush signal bundle of the icache controller.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; once the producer raises valid it holds it (and its payload) until
// that transfer, except where a fetch kill explicitly abandons the request.
interface sargantana_icache_ctrl_if;
  import sargantana_icache_pkg::*;

  logic     req_valid_i;
  logic     req_ready_o;
  logic     req_kill_i;
  logic     tag_valid_i;
  way_vec_t cline_hit_i;
  way_vec_t way_valid_bits_i;
  logic     cmp_enable_o;
  logic     resp_valid_o;
  logic     mem_req_valid_o;
  logic     mem_req_ready_i;
  logic     mem_rsp_valid_i;
  way_vec_t way_we_o;
  logic     flush_i;
  logic     flush_done_o;
  set_idx_t flush_idx_o;
  logic     valid_clr_o;
  logic     busy_o;

  modport slave (
    input  req_valid_i, req_kill_i, tag_valid_i, cline_hit_i, way_valid_bits_i,
           mem_req_ready_i, mem_rsp_valid_i, flush_i,
    output req_ready_o, cmp_enable_o, resp_valid_o, mem_req_valid_o, way_we_o,
           flush_done_o, flush_idx_o, valid_clr_o, busy_o
  );

  modport master (
    output req_valid_i, req_kill_i, tag_valid_i, cline_hit_i, way_valid_bits_i,
           mem_req_ready_i, mem_rsp_valid_i, flush_i,
    input  req_ready_o, cmp_enable_o, resp_valid_o, mem_req_valid_o, way_we_o,
           flush_done_o, flush_idx_o, valid_clr_o, busy_o
  );

endinterface

// File: rtl/sargantana_icache_replace.sv
// Victim-way selection: first invalid way, else pseudo-random from an LFSR.
// The victim is latched on the miss cycle and the LFSR steps once per miss.
module sargantana_icache_replace
  import sargantana_icache_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic     clk_i,
  input  logic     rstn_i,
  input  logic     miss_i,
  input  way_vec_t way_valid_bits_i,
  output way_vec_t victim_oh_o
);

  logic [7:0]                  lfsr_q;
  way_vec_t                    victim_q;
  logic                        free_found;
  logic [ICACHE_WAY_IDX_W-1:0] free_idx;
  logic [ICACHE_WAY_IDX_W-1:0] sel_idx;

  // Pick the lowest-index invalid way; fall back to the LFSR low bits.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int w = ICACHE_N_WAY - 1; w >= 0; w--) begin
      if (!way_valid_bits_i[w]) begin
        free_found = 1'b1;
        free_idx   = ICACHE_WAY_IDX_W'(w);
      end
    end
    sel_idx = free_found ? free_idx : lfsr_q[ICACHE_WAY_IDX_W-1:0];
  end

  // Latch the victim and advance the LFSR on each miss.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      lfsr_q   <= LFSR_SEED;
      victim_q <= '0;
    end else if (miss_i) begin
      lfsr_q   <= lfsr_next(lfsr_q);
      victim_q <= way_vec_t'(1) << sel_idx;
    end
  end

  assign victim_oh_o = victim_q;

endmodule

// File: rtl/sargantana_icache_ctrl.sv
// Sargantana instruction-cache controller: lookup, miss/refill, kill and
// invalidate-all flush sequencing.
// Optional hit/miss counters are built when ICACHE_PERF_CNT_EN is defined.
module sargantana_icache_ctrl
  import sargantana_icache_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  sargantana_icache_ctrl_if.slave bus,
  output icache_state_e           dbg_state_o
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]             hit_cnt_o,
  output logic [31:0]             miss_cnt_o
`endif
);

  icache_state_e state_q, state_d;
  set_idx_t      flush_cnt_q;
  logic          flush_pend_q;
  logic          killed_q;
  logic          any_hit;
  logic          hit_event;
  logic          miss_event;
  logic          flush_last;
  way_vec_t      victim_oh;

  assign any_hit    = |bus.cline_hit_i;
  assign hit_event  = (state_q == COMPARE) && bus.tag_valid_i && any_hit && !bus.req_kill_i;
  assign miss_event = (state_q == COMPARE) && bus.tag_valid_i && !any_hit && !bus.req_kill_i;
  assign flush_last = (flush_cnt_q == set_idx_t'(ICACHE_N_SETS - 1));

  sargantana_icache_replace #(
    .LFSR_SEED (LFSR_SEED)
  ) u_replace (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .miss_i           (miss_event),
    .way_valid_bits_i (bus.way_valid_bits_i),
    .victim_oh_o      (victim_oh)
  );

  // State register plus the flush counter, pending-flush and killed flags.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      flush_cnt_q  <= '0;
      flush_pend_q <= 1'b0;
      killed_q     <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == FLUSH && !flush_last) flush_cnt_q <= flush_cnt_q + 1'b1;
      else                                 flush_cnt_q <= '0;

      // A flush arriving mid-transaction waits until the controller is free.
      if (state_d == FLUSH)
        flush_pend_q <= 1'b0;
      else if (bus.flush_i && state_q != IDLE && state_q != FLUSH)
        flush_pend_q <= 1'b1;

      // Once the memory request is in flight, a kill only suppresses the response.
      if (state_d == IDLE)
        killed_q <= 1'b0;
      else if (bus.req_kill_i && (state_q inside {MISS_REQ, MISS_WAIT, KILL_WAIT}))
        killed_q <= 1'b1;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.flush_i || flush_pend_q) state_d = FLUSH;
        else if (bus.req_valid_i)        state_d = COMPARE;
      end
      COMPARE: begin
        if (bus.req_kill_i)       state_d = IDLE;
        else if (bus.tag_valid_i) state_d = any_hit ? IDLE : MISS_REQ;
      end
      MISS_REQ: begin
        // A kill in the handshake cycle still leaves a line fill outstanding.
        if (bus.mem_req_ready_i) state_d = bus.req_kill_i ? KILL_WAIT : MISS_WAIT;
        else if (bus.req_kill_i) state_d = IDLE;
      end
      MISS_WAIT: begin
        if (bus.mem_rsp_valid_i) state_d = REFILL;
        else if (bus.req_kill_i) state_d = KILL_WAIT;
      end
      KILL_WAIT: begin
        if (bus.mem_rsp_valid_i) state_d = REFILL;
      end
      REFILL: begin
        state_d = (flush_pend_q || bus.flush_i) ? FLUSH : IDLE;
      end
      FLUSH: begin
        if (flush_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current state and inputs.
  always_comb begin
    bus.req_ready_o     = (state_q == IDLE) && !bus.flush_i && !flush_pend_q;
    bus.cmp_enable_o    = (state_q == COMPARE) && bus.tag_valid_i;
    bus.resp_valid_o    = hit_event ||
                          ((state_q == REFILL) && !killed_q && !bus.req_kill_i);
    bus.mem_req_valid_o = (state_q == MISS_REQ);
    bus.way_we_o        = (state_q == REFILL) ? victim_oh : '0;
    bus.valid_clr_o     = (state_q == FLUSH);
    bus.flush_idx_o     = (state_q == FLUSH) ? flush_cnt_q : '0;
    bus.flush_done_o    = (state_q == FLUSH) && flush_last;
    bus.busy_o          = (state_q != IDLE);
    dbg_state_o         = state_q;
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Saturating lookup outcome counters.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_event && hit_cnt_q != 32'hFFFF_FFFF)   hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (miss_event && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_sargantana_icache_ctrl.sv
// Directed bench for sargantana_icache_ctrl with an event scoreboard.
module tb_sargantana_icache_ctrl;
  import sargantana_icache_pkg::*;

  localparam int EW = 44;

  logic          clk = 1'b0;
  logic          rstn_i;
  icache_state_e dbg_state;
  int unsigned   cyc = 0;
  int            n_checks = 0;
  int            n_errors = 0;
  logic [EW-1:0] exp_q[$];

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  sargantana_icache_ctrl_if bus_if ();

  sargantana_icache_ctrl #(.LFSR_SEED(8'hA5)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .bus         (bus_if.slave),
    .dbg_state_o (dbg_state)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt_o   (hit_cnt),
    .miss_cnt_o  (miss_cnt)
`endif
  );

  // clock and cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // event word: {cycle, resp, mem_req, way_we, valid_clr, flush_done, flush_idx}
  function automatic logic [EW-1:0] mk(input int unsigned c, input bit resp, input bit memreq,
                                       input logic [3:0] we, input bit clr, input bit done,
                                       input logic [3:0] idx);
    return {c, resp, memreq, we, clr, done, idx};
  endfunction

  task automatic expect_ev(input int unsigned c, input bit resp, input bit memreq,
                           input logic [3:0] we, input bit clr, input bit done,
                           input logic [3:0] idx);
    exp_q.push_back(mk(c, resp, memreq, we, clr, done, idx));
  endtask

  // monitor: every visible output event must match the head of the queue
  always @(negedge clk) begin
    logic [EW-1:0] ev;
    logic [EW-1:0] e;
    ev = mk(cyc, bus_if.resp_valid_o, bus_if.mem_req_valid_o, bus_if.way_we_o,
            bus_if.valid_clr_o, bus_if.flush_done_o, bus_if.flush_idx_o);
    if (bus_if.resp_valid_o || bus_if.mem_req_valid_o || (|bus_if.way_we_o) ||
        bus_if.valid_clr_o || bus_if.flush_done_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: got 0x%0h expected none (cycle %0d)", ev, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("event", ev, e);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus_if.req_valid_i      = 1'b0;
    bus_if.req_kill_i       = 1'b0;
    bus_if.tag_valid_i      = 1'b0;
    bus_if.cline_hit_i      = '0;
    bus_if.way_valid_bits_i = '1;
    bus_if.mem_req_ready_i  = 1'b1;
    bus_if.mem_rsp_valid_i  = 1'b0;
    bus_if.flush_i          = 1'b0;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    clear_inputs();
    tick();
    tick();
    rstn_i = 1'b1;
  endtask

  task automatic start_req(input bit tv, input logic [3:0] hit, input logic [3:0] wv);
    bus_if.req_valid_i      = 1'b1;
    bus_if.tag_valid_i      = tv;
    bus_if.cline_hit_i      = hit;
    bus_if.way_valid_bits_i = wv;
  endtask

  task automatic check_idle(input string name);
    chk(name, 64'(dbg_state), 64'(IDLE));
  endtask

  // full miss: handshake at A+2, response after d idle MISS_WAIT cycles
  task automatic miss_seq(input logic [3:0] wv, input logic [3:0] exp_we, input int d);
    int unsigned a;
    a = cyc;
    start_req(1'b1, 4'b0000, wv);
    expect_ev(a + 2, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0);
    expect_ev(a + 4 + d, 1'b1, 1'b0, exp_we, 1'b0, 1'b0, 4'd0);
    tick();
    bus_if.req_valid_i = 1'b0;
    tick();
    bus_if.tag_valid_i = 1'b0;
    tick();
    for (int i = 0; i < d; i++) tick();
    bus_if.mem_rsp_valid_i = 1'b1;
    tick();
    bus_if.mem_rsp_valid_i = 1'b0;
    tick();
    sample();
    check_idle("miss_back_to_idle");
    tick();
  endtask

  initial begin : stim
    int unsigned a;

    // reset values
    do_reset();
    rstn_i = 1'b0;
    sample();
    chk("rst_req_ready", bus_if.req_ready_o, 1);
    chk("rst_busy", bus_if.busy_o, 0);
    chk("rst_resp_valid", bus_if.resp_valid_o, 0);
    chk("rst_mem_req", bus_if.mem_req_valid_o, 0);
    chk("rst_way_we", bus_if.way_we_o, 0);
    chk("rst_valid_clr", bus_if.valid_clr_o, 0);
    chk("rst_flush_done", bus_if.flush_done_o, 0);
    chk("rst_cmp_enable", bus_if.cmp_enable_o, 0);
    tick();
    rstn_i = 1'b1;

    // hit with tag valid immediately: response one cycle after acceptance
    a = cyc;
    start_req(1'b1, 4'b0010, 4'b1111);
    expect_ev(a + 1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd0);
    tick();
    bus_if.req_valid_i = 1'b0;
    sample();
    chk("hit_cmp_enable", bus_if.cmp_enable_o, 1);
    tick();
    clear_inputs();
    sample();
    check_idle("hit_idle");
    tick();

    // hit with the tag arriving one cycle late
    a = cyc;
    start_req(1'b0, 4'b0010, 4'b1111);
    expect_ev(a + 2, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd0);
    tick();
    bus_if.req_valid_i = 1'b0;
    sample();
    chk("late_tag_cmp_enable", bus_if.cmp_enable_o, 0);
    chk("late_tag_state", 64'(dbg_state), 64'(COMPARE));
    tick();
    bus_if.tag_valid_i = 1'b1;
    tick();
    clear_inputs();
    tick();

    // miss with an invalid way: way 2 is the first free one
    miss_seq(4'b1011, 4'b0100, 0);

    // all ways valid: LFSR from A5 gives victims way1, then way2 (after 4A)
    do_reset();
    miss_seq(4'b1111, 4'b0010, 0);
    miss_seq(4'b1111, 4'b0100, 2);

    // kill after the memory handshake, response 5 cycles later
    a = cyc;
    start_req(1'b1, 4'b0000, 4'b0111);
    expect_ev(a + 2, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0);
    expect_ev(a + 9, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 4'd0);
    tick();
    bus_if.req_valid_i = 1'b0;
    tick();
    bus_if.tag_valid_i = 1'b0;
    tick();
    bus_if.req_kill_i = 1'b1;
    tick();
    bus_if.req_kill_i = 1'b0;
    sample();
    chk("kill_wait_state", 64'(dbg_state), 64'(KILL_WAIT));
    tick();
    tick();
    tick();
    tick();
    bus_if.mem_rsp_valid_i = 1'b1;
    tick();
    bus_if.mem_rsp_valid_i = 1'b0;
    tick();
    sample();
    check_idle("kill_after_hs_idle");
    chk("kill_after_hs_busy", bus_if.busy_o, 0);
    tick();

    // kill in COMPARE while hitting: no response
    start_req(1'b1, 4'b0010, 4'b1111);
    tick();
    bus_if.req_valid_i = 1'b0;
    bus_if.req_kill_i  = 1'b1;
    sample();
    chk("kill_cmp_no_resp", bus_if.resp_valid_o, 0);
    tick();
    clear_inputs();
    sample();
    check_idle("kill_cmp_idle");
    tick();

    // kill in MISS_REQ before the handshake
    a = cyc;
    bus_if.mem_req_ready_i = 1'b0;
    start_req(1'b1, 4'b0000, 4'b1111);
    expect_ev(a + 2, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0);
    tick();
    bus_if.req_valid_i = 1'b0;
    tick();
    bus_if.tag_valid_i = 1'b0;
    bus_if.req_kill_i  = 1'b1;
    tick();
    clear_inputs();
    sample();
    check_idle("kill_missreq_idle");
    tick();
    tick();

    // flush from IDLE, with a competing request that must lose
    a = cyc;
    bus_if.flush_i     = 1'b1;
    bus_if.req_valid_i = 1'b1;
    for (int i = 0; i < ICACHE_N_SETS; i++)
      expect_ev(a + 1 + i, 1'b0, 1'b0, 4'b0000, 1'b1, (i == ICACHE_N_SETS - 1), 4'(i));
    sample();
    chk("flush_blocks_req_ready", bus_if.req_ready_o, 0);
    tick();
    clear_inputs();
    for (int i = 0; i < ICACHE_N_SETS; i++) tick();
    sample();
    check_idle("flush_idle");
    tick();

    // flush during a miss is held until the refill completes
    a = cyc;
    start_req(1'b1, 4'b0000, 4'b1101);
    expect_ev(a + 2, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0);
    expect_ev(a + 5, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < ICACHE_N_SETS; i++)
      expect_ev(a + 6 + i, 1'b0, 1'b0, 4'b0000, 1'b1, (i == ICACHE_N_SETS - 1), 4'(i));
    tick();
    bus_if.req_valid_i = 1'b0;
    tick();
    bus_if.tag_valid_i = 1'b0;
    tick();
    bus_if.flush_i = 1'b1;
    tick();
    bus_if.flush_i         = 1'b0;
    bus_if.mem_rsp_valid_i = 1'b1;
    tick();
    bus_if.mem_rsp_valid_i = 1'b0;
    for (int i = 0; i < ICACHE_N_SETS + 1; i++) tick();
    sample();
    check_idle("pending_flush_idle");
    tick();

    // reset in MISS_WAIT, then a late response that must be ignored
    a = cyc;
    start_req(1'b1, 4'b0000, 4'b1111);
    expect_ev(a + 2, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0);
    tick();
    bus_if.req_valid_i = 1'b0;
    tick();
    bus_if.tag_valid_i = 1'b0;
    tick();
    sample();
    chk("pre_reset_state", 64'(dbg_state), 64'(MISS_WAIT));
    rstn_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    bus_if.mem_rsp_valid_i = 1'b1;
    sample();
    chk("late_rsp_way_we", bus_if.way_we_o, 0);
    check_idle("late_rsp_idle_a");
    tick();
    bus_if.mem_rsp_valid_i = 1'b0;
    sample();
    chk("late_rsp_way_we_b", bus_if.way_we_o, 0);
    check_idle("late_rsp_idle_b");
    tick();
    tick();

    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sargantana_icache_ctrl.md
SARGANTANA_ICACHE_CTRL -- requirements
Module: sargantana_icache_ctrl

Interface
REQ-001 Parameter: LFSR_SEED, default 8'hA5, nonzero reset seed of the replacement LFSR.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rstn_i  input  1  synchronous, active-low reset.
REQ-004 req_valid_i  input  1  fetch lookup request; the index is already presented to the tag/data arrays.
REQ-005 req_ready_o  output  1  controller can accept a lookup this cycle.
REQ-006 req_kill_i  input  1  fetch redirect; abandons the current request.
REQ-007 tag_valid_i  input  1  MMU physical tag (cline_tag_d) is valid this cycle.
REQ-008 cline_hit_i  input  ICACHE_N_WAY  per-way hit vector from the tag checker.
REQ-009 way_valid_bits_i  input  ICACHE_N_WAY  valid bits of the indexed set.
REQ-010 cmp_enable_o  output  1  qualifies the checker compare cycle.
REQ-011 resp_valid_o  output  1  one-cycle pulse; fetch data (hit or refill) is valid.
REQ-012 mem_req_valid_o / mem_req_ready_i  output / input  1 / 1  line-fill request handshake.
REQ-013 mem_rsp_valid_i  input  1  full line returned on ifill_data.
REQ-014 way_we_o  output  ICACHE_N_WAY  one-hot tag/data/valid write enable for the refill.
REQ-015 flush_i / flush_done_o  input / output  1 / 1  invalidate-all request / one-cycle completion pulse.
REQ-016 flush_idx_o  output  ICACHE_IDX_WIDTH  set index being invalidated; valid_clr_o (output, 1) qualifies it.
REQ-017 busy_o  output  1  state other than IDLE.

Function
REQ-018 States SHALL be IDLE, COMPARE, MISS_REQ, MISS_WAIT, REFILL, FLUSH, KILL_WAIT.
REQ-019 IDLE: req_ready_o=1; req_valid_i & !flush_i -> COMPARE next cycle; flush_i has priority over req_valid_i.
REQ-020 COMPARE: cmp_enable_o=tag_valid_i; stay while !tag_valid_i; with tag_valid_i and |cline_hit_i -> resp_valid_o=1 same cycle, -> IDLE; with tag_valid_i and no hit -> MISS_REQ.
REQ-021 Hit latency SHALL be 1 cycle after acceptance when the tag is valid immediately.
REQ-022 MISS_REQ: mem_req_valid_o=1 held until mem_req_ready_i; on handshake -> MISS_WAIT; victim way latched at entry.
REQ-023 Victim: lowest-index way with way_valid_bits_i=0; if all valid, LFSR[log2(N_WAY)-1:0].
REQ-024 LFSR: 8-bit Fibonacci, taps 8,6,5,4; advances once per miss.
REQ-025 MISS_WAIT: on mem_rsp_valid_i -> REFILL.
REQ-026 REFILL: way_we_o=onehot(victim) for exactly one cycle, resp_valid_o=1 same cycle, -> IDLE.
REQ-027 req_kill_i in COMPARE or MISS_REQ before handshake -> IDLE, no response, no memory request.
REQ-028 req_kill_i after the memory handshake -> KILL_WAIT; the line SHALL still be written on return (way_we_o pulse), with resp_valid_o=0, -> IDLE.
REQ-029 resp_valid_o SHALL never assert in a cycle where req_kill_i=1.
REQ-030 FLUSH: flush_idx_o counts 0..ICACHE_N_SETS-1, one set per cycle, valid_clr_o=1; at the last index, flush_done_o=1 and -> IDLE.
REQ-031 flush_i during a miss SHALL be held pending until the refill completes, then FLUSH is entered.
REQ-032 mem_rsp_valid_i outside MISS_WAIT/KILL_WAIT SHALL be ignored.

Reset
REQ-033 rstn_i=0 at a clock edge -> IDLE, LFSR=LFSR_SEED, flush counter=0, pending flush cleared.
REQ-034 All outputs SHALL be 0 during and after reset except req_ready_o=1.
REQ-035 Reset mid-miss SHALL drop the outstanding request; a late response SHALL be ignored per REQ-032.

Configuration
REQ-036 Macro ICACHE_PERF_CNT_EN: when defined, adds 32-bit outputs hit_cnt_o and miss_cnt_o, incremented on REQ-020 hit/miss and saturating at 32'hFFFFFFFF, reset to 0.
REQ-037 Without the macro, those ports and counters SHALL NOT exist; all other behaviour is identical.

Structure
REQ-038 State enum, ICACHE_IDX_WIDTH and ICACHE_N_SETS SHALL live in sargantana_icache_pkg with ICACHE_N_WAY.
REQ-039 Victim selection (REQ-023/024) SHALL be sub-module sargantana_icache_replace.

Verification
REQ-040 Reset, then req_valid_i=1, tag_valid_i=1, cline_hit_i=4'b0010 -> resp_valid_o=1 one cycle after acceptance; no mem_req_valid_o.
REQ-041 Miss with way_valid_bits_i=4'b1011 -> way_we_o=4'b0100 on the response cycle; resp_valid_o=1 same cycle.
REQ-042 Two misses with all ways valid, seed 8'hA5 -> victims match the REQ-024 LFSR model sequence.
REQ-043 Miss, kill after handshake, response 5 cycles later -> way_we_o pulse, resp_valid_o=0, then IDLE.
REQ-044 flush_i in IDLE -> valid_clr_o for ICACHE_N_SETS consecutive cycles, idx 0..N-1, flush_done_o on the last.
REQ-045 rstn_i=0 in MISS_WAIT, then mem_rsp_valid_i=1 -> way_we_o stays 0, state IDLE.
